// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file. Two write ports, optional write-to-read
//            bypass, per-register pending scoreboard and soft-flush sweep.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [AW-1:0]     rna,
    input  logic [AW-1:0]     rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    input  logic              we0,
    input  logic [AW-1:0]     wn0,
    input  logic [DATA_W-1:0] d0,
    input  logic              we1,
    input  logic [AW-1:0]     wn1,
    input  logic [DATA_W-1:0] d1,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_wn,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              flush_req,
    output logic              flush_busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_ptr;
    logic [DATA_W-1:0]   r_mem [1:NREG-1];
    logic [NREG-1:1]     r_pend;

    assign flush_busy = (r_state == ST_SWEEP);

    // r0 and out-of-range addresses simply never match an entry, so they read 0.
    function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] addr);
        logic [DATA_W-1:0] v;
        logic              hit;
        v   = '0;
        hit = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                v   = r_mem[i];
                hit = 1'b1;
            end
        end
        if ((BYPASS != 0) && hit && !flush_busy) begin
            if (we1 && (wn1 == addr)) begin
                v = d1;
            end else if (we0 && (wn0 == addr)) begin
                v = d0;
            end
        end
        return v;
    endfunction

    function automatic logic f_busy(input logic [AW-1:0] addr);
        logic b;
        b = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                b = r_pend[i];
            end
        end
        return b;
    endfunction

    always_comb begin
        qa     = f_read(rna);
        qb     = f_read(rnb);
        busy_a = f_busy(rna);
        busy_b = f_busy(rnb);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_pend  <= '0;
            for (int i = 1; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    for (int i = 1; i < NREG; i++) begin
                        if (we1 && (wn1 == AW'(i))) begin
                            r_mem[i] <= d1;
                        end else if (we0 && (wn0 == AW'(i))) begin
                            r_mem[i] <= d0;
                        end
                        // A new reservation outlives the older write landing on the same edge.
                        if (rsv_en && (rsv_wn == AW'(i))) begin
                            r_pend[i] <= 1'b1;
                        end else if ((we1 && (wn1 == AW'(i))) || (we0 && (wn0 == AW'(i)))) begin
                            r_pend[i] <= 1'b0;
                        end
                    end
                    if (flush_req) begin
                        r_state <= ST_SWEEP;
                        r_ptr   <= AW'(1);
                    end
                end
                ST_SWEEP: begin
                    for (int i = 1; i < NREG; i++) begin
                        if (r_ptr == AW'(i)) begin
                            r_mem[i]  <= '0;
                            r_pend[i] <= 1'b0;
                        end
                    end
                    if (r_ptr == AW'(NREG - 1)) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
